// File: rtl/fc_l2_port_arbiter_pkg.sv
// rtl/fc_l2_port_arbiter_pkg.sv - shared types and defaults for the FC L2 port arbiter
package fc_l2_arb_pkg;

    localparam int ARB_N_PORTS         = 5;
    localparam int ARB_ADDR_WIDTH      = 32;
    localparam int ARB_DATA_WIDTH      = 32;
    localparam int ARB_MAX_OUTSTANDING = 4;

    localparam int CORE_PORT_IDX = 0;

    typedef logic [$clog2(ARB_N_PORTS)-1:0] idx_t;

    typedef struct packed {
        logic [ARB_ADDR_WIDTH-1:0]   add;
        logic                        wen;
        logic [ARB_DATA_WIDTH-1:0]   wdata;
        logic [ARB_DATA_WIDTH/8-1:0] be;
    } req_t;

    // Round-robin successor of a port index, wrapping at n.
    function automatic int next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fc_l2_port_arbiter_if.sv
// rtl/fc_l2_port_arbiter_if.sv - requester and L2 side bundle of the FC L2 port arbiter
interface fc_l2_port_arbiter_if
    import fc_l2_arb_pkg::*;
#(
    parameter int N_PORTS         = ARB_N_PORTS,
    parameter int ADDR_WIDTH      = ARB_ADDR_WIDTH,
    parameter int DATA_WIDTH      = ARB_DATA_WIDTH,
    parameter int MAX_OUTSTANDING = ARB_MAX_OUTSTANDING
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int USE_W = $clog2(MAX_OUTSTANDING) + 1;

    logic [N_PORTS-1:0]            m_req_i;
    logic [N_PORTS*ADDR_WIDTH-1:0] m_add_i;
    logic [N_PORTS-1:0]            m_wen_i;
    logic [N_PORTS*DATA_WIDTH-1:0] m_wdata_i;
    logic [N_PORTS*BE_W-1:0]       m_be_i;
    logic [N_PORTS-1:0]            m_gnt_o;
    logic [N_PORTS-1:0]            m_r_valid_o;
    logic [DATA_WIDTH-1:0]         m_r_rdata_o;
    logic                          m_r_opc_o;

    logic                          s_req_o;
    logic [ADDR_WIDTH-1:0]         s_add_o;
    logic                          s_wen_o;
    logic [DATA_WIDTH-1:0]         s_wdata_o;
    logic [BE_W-1:0]               s_be_o;
    logic                          s_gnt_i;
    logic                          s_r_valid_i;
    logic [DATA_WIDTH-1:0]         s_r_rdata_i;
    logic                          s_r_opc_i;

    logic [USE_W-1:0]              outstanding_o;
    logic                          proto_err_o;

    modport slave (
        input  m_req_i, m_add_i, m_wen_i, m_wdata_i, m_be_i,
        output m_gnt_o, m_r_valid_o, m_r_rdata_o, m_r_opc_o,
        output s_req_o, s_add_o, s_wen_o, s_wdata_o, s_be_o,
        input  s_gnt_i, s_r_valid_i, s_r_rdata_i, s_r_opc_i,
        output outstanding_o, proto_err_o
    );

    modport master (
        output m_req_i, m_add_i, m_wen_i, m_wdata_i, m_be_i,
        input  m_gnt_o, m_r_valid_o, m_r_rdata_o, m_r_opc_o,
        input  s_req_o, s_add_o, s_wen_o, s_wdata_o, s_be_o,
        output s_gnt_i, s_r_valid_i, s_r_rdata_i, s_r_opc_i,
        input  outstanding_o, proto_err_o
    );

endinterface

// File: rtl/fc_l2_port_arbiter_rsp_id_fifo.sv
// rtl/fc_l2_port_arbiter_rsp_id_fifo.sv - in-order FIFO of granted port indices awaiting a response
module fc_l2_rsp_id_fifo
    import fc_l2_arb_pkg::*;
#(
    parameter int DEPTH = ARB_MAX_OUTSTANDING,
    parameter int WIDTH = $bits(idx_t)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   usage_o
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rptr_q];
    assign usage_o = cnt_q;

    // Head is only ever read from storage, so a push never falls through to the same cycle's pop.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_push) begin
            mem_d[wptr_q] = data_i;
            wptr_d        = wptr_q + PW'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (PW+1)'(1);
            2'b01:   cnt_d = cnt_q - (PW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/fc_l2_port_arbiter.sv
// rtl/fc_l2_port_arbiter.sv - round-robin arbiter sharing one L2 master port among FC requesters
module fc_l2_port_arbiter
    import fc_l2_arb_pkg::*;
#(
    parameter int N_PORTS         = ARB_N_PORTS,
    parameter int ADDR_WIDTH      = ARB_ADDR_WIDTH,
    parameter int DATA_WIDTH      = ARB_DATA_WIDTH,
    parameter int MAX_OUTSTANDING = ARB_MAX_OUTSTANDING
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    fc_l2_port_arbiter_if.slave    bus
);
    localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int USE_W = $clog2(MAX_OUTSTANDING) + 1;

    logic [IDX_W-1:0]      rr_q, rr_d;
    logic [IDX_W-1:0]      lock_idx_q, lock_idx_d;
    logic                  lock_q, lock_d;
    logic                  proto_err_q, proto_err_d;

    logic [IDX_W-1:0]      scan_idx, sel, fifo_head;
    logic [N_PORTS-1:0]    req_masked;
    logic                  found, any_req, s_req, grant;
    logic                  fifo_full, fifo_empty, fifo_pop;
    logic [USE_W-1:0]      fifo_usage;
    int                    cand;

    logic [ADDR_WIDTH-1:0] add_arr   [N_PORTS];
    logic [DATA_WIDTH-1:0] wdata_arr [N_PORTS];
    logic [BE_W-1:0]       be_arr    [N_PORTS];

    for (genvar g = 0; g < N_PORTS; g++) begin : g_unpack
        assign add_arr[g]   = bus.m_add_i[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[g] = bus.m_wdata_i[g*DATA_WIDTH +: DATA_WIDTH];
        assign be_arr[g]    = bus.m_be_i[g*BE_W +: BE_W];
    end

    // A full ID FIFO blocks new arbitration entirely; a held lock cannot coexist with full.
    assign req_masked = fifo_full ? '0 : bus.m_req_i;
    assign any_req    = |req_masked;

    always_comb begin
        scan_idx = rr_q;
        found    = 1'b0;
        cand     = 0;
        for (int i = 0; i < N_PORTS; i++) begin
            cand = int'(rr_q) + i;
            if (cand >= N_PORTS) cand = cand - N_PORTS;
            if (!found && req_masked[cand[IDX_W-1:0]]) begin
                found    = 1'b1;
                scan_idx = cand[IDX_W-1:0];
            end
        end
    end

    assign sel      = lock_q ? lock_idx_q : scan_idx;
    assign s_req    = any_req | lock_q;
    assign grant    = s_req & bus.s_gnt_i;
    assign fifo_pop = bus.s_r_valid_i & ~fifo_empty;

    always_comb begin
        rr_d        = rr_q;
        lock_d      = s_req & ~bus.s_gnt_i;
        lock_idx_d  = lock_idx_q;
        proto_err_d = proto_err_q | (bus.s_r_valid_i & fifo_empty);
        if (grant) rr_d = IDX_W'(next_idx(int'(sel), N_PORTS));
        if (lock_d) lock_idx_d = sel;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_q        <= '0;
            lock_q      <= 1'b0;
            lock_idx_q  <= '0;
            proto_err_q <= 1'b0;
        end else begin
            rr_q        <= rr_d;
            lock_q      <= lock_d;
            lock_idx_q  <= lock_idx_d;
            proto_err_q <= proto_err_d;
        end
    end

    fc_l2_rsp_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IDX_W)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (grant),
        .data_i  (sel),
        .pop_i   (fifo_pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head),
        .usage_o (fifo_usage)
    );

    always_comb begin
        bus.m_gnt_o     = '0;
        bus.m_r_valid_o = '0;
        if (grant)    bus.m_gnt_o[sel]           = 1'b1;
        if (fifo_pop) bus.m_r_valid_o[fifo_head] = 1'b1;
    end

    assign bus.s_req_o       = s_req;
    assign bus.s_add_o       = add_arr[sel];
    assign bus.s_wen_o       = bus.m_wen_i[sel];
    assign bus.s_wdata_o     = wdata_arr[sel];
    assign bus.s_be_o        = be_arr[sel];
    assign bus.m_r_rdata_o   = bus.s_r_rdata_i;
    assign bus.m_r_opc_o     = bus.s_r_opc_i;
    assign bus.outstanding_o = fifo_usage;
    assign bus.proto_err_o   = proto_err_q;

endmodule

// File: tb/tb_fc_l2_port_arbiter.sv
// tb/tb_fc_l2_port_arbiter.sv - table-driven bench with response scoreboard for fc_l2_port_arbiter
module tb_fc_l2_port_arbiter;
    localparam int NP = 5;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 4;

    logic clk = 1'b0;
    logic rst_ni;
    always #5 clk = ~clk;

    fc_l2_port_arbiter_if #(.N_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) bus ();

    fc_l2_port_arbiter #(.N_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    typedef struct {
        logic [NP-1:0] req;
        logic          gnt;
        logic          rv;
        logic          opc;
        logic [NP-1:0] exp_gnt;
        logic          exp_sreq;
        int            exp_sel;
        int            exp_out;
    } vec_t;

    vec_t vecs [$];
    int   sb_q [$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [AW-1:0] addr_of(input int p);
        return 32'h1000_0000 + 32'(p * 16);
    endfunction
    function automatic logic [DW-1:0] wdata_of(input int p);
        return 32'hD00D_0000 + 32'(p);
    endfunction
    function automatic logic [3:0] be_of(input int p);
        return 4'hF ^ 4'(p);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [NP-1:0] req, input logic g, input logic rv, input logic opc,
                                input logic [NP-1:0] eg, input logic es, input int esel, input int eo);
        vec_t v;
        v.req = req; v.gnt = g; v.rv = rv; v.opc = opc;
        v.exp_gnt = eg; v.exp_sreq = es; v.exp_sel = esel; v.exp_out = eo;
        return v;
    endfunction

    task automatic drive(input logic [NP-1:0] req, input logic g, input logic rv, input logic opc,
                         input logic [DW-1:0] rd);
        @(posedge clk);
        #1;
        bus.m_req_i     = req;
        bus.s_gnt_i     = g;
        bus.s_r_valid_i = rv;
        bus.s_r_opc_i   = opc;
        bus.s_r_rdata_i = rd;
    endtask

    // Response checks: a valid from L2 must go to the oldest still-pending winner.
    task automatic check_rsp(input logic rv, input logic opc, input logic [DW-1:0] rd);
        logic [NP-1:0] exp_rv;
        exp_rv = '0;
        if (rv && sb_q.size() > 0) exp_rv = NP'(1) << sb_q.pop_front();
        chk("m_r_valid", 64'(bus.m_r_valid_o), 64'(exp_rv));
        if (rv) begin
            chk("m_r_rdata", 64'(bus.m_r_rdata_o), 64'(rd));
            chk("m_r_opc", 64'(bus.m_r_opc_o), 64'(opc));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] rd;
        rst_ni = 1'b0;
        bus.m_req_i = '0; bus.s_gnt_i = 1'b0; bus.s_r_valid_i = 1'b0;
        bus.s_r_opc_i = 1'b0; bus.s_r_rdata_i = '0;
        for (int p = 0; p < NP; p++) begin
            bus.m_add_i[p*AW +: AW]   = addr_of(p);
            bus.m_wdata_i[p*DW +: DW] = wdata_of(p);
            bus.m_be_i[p*4 +: 4]      = be_of(p);
            bus.m_wen_i[p]            = p[0];
        end

        // single read, round robin 2/4/0, lock, dropped req under lock, fill to full, opc ordering
        vecs.push_back(mk(5'b00001,1,0,0, 5'b00001,1, 0,0));
        vecs.push_back(mk(5'b00000,0,0,0, 5'b00000,0,-1,1));
        vecs.push_back(mk(5'b00000,0,1,0, 5'b00000,0,-1,1));
        vecs.push_back(mk(5'b00000,0,0,0, 5'b00000,0,-1,0));
        vecs.push_back(mk(5'b10101,1,0,0, 5'b00100,1, 2,0));
        vecs.push_back(mk(5'b10101,1,1,0, 5'b10000,1, 4,1));
        vecs.push_back(mk(5'b10101,1,1,0, 5'b00001,1, 0,1));
        vecs.push_back(mk(5'b10101,1,1,0, 5'b00100,1, 2,1));
        vecs.push_back(mk(5'b10101,1,1,0, 5'b10000,1, 4,1));
        vecs.push_back(mk(5'b10101,1,1,0, 5'b00001,1, 0,1));
        vecs.push_back(mk(5'b00000,0,1,0, 5'b00000,0,-1,1));
        vecs.push_back(mk(5'b01010,0,0,0, 5'b00000,1, 1,0));
        vecs.push_back(mk(5'b01010,0,0,0, 5'b00000,1, 1,0));
        vecs.push_back(mk(5'b01010,0,0,0, 5'b00000,1, 1,0));
        vecs.push_back(mk(5'b01010,1,0,0, 5'b00010,1, 1,0));
        vecs.push_back(mk(5'b01000,1,0,0, 5'b01000,1, 3,1));
        vecs.push_back(mk(5'b00100,0,0,0, 5'b00000,1, 2,2));
        vecs.push_back(mk(5'b00000,0,0,0, 5'b00000,1, 2,2));
        vecs.push_back(mk(5'b00001,1,0,0, 5'b00100,1, 2,2));
        vecs.push_back(mk(5'b00000,0,1,0, 5'b00000,0,-1,3));
        vecs.push_back(mk(5'b00000,0,1,0, 5'b00000,0,-1,2));
        vecs.push_back(mk(5'b00000,0,1,0, 5'b00000,0,-1,1));
        vecs.push_back(mk(5'b00000,0,0,0, 5'b00000,0,-1,0));
        vecs.push_back(mk(5'b00011,1,0,0, 5'b00001,1, 0,0));
        vecs.push_back(mk(5'b00011,1,0,0, 5'b00010,1, 1,1));
        vecs.push_back(mk(5'b00011,1,0,0, 5'b00001,1, 0,2));
        vecs.push_back(mk(5'b00011,1,0,0, 5'b00010,1, 1,3));
        vecs.push_back(mk(5'b00011,1,0,0, 5'b00000,0,-1,4));
        vecs.push_back(mk(5'b00011,1,1,0, 5'b00000,0,-1,4));
        vecs.push_back(mk(5'b00011,1,0,0, 5'b00001,1, 0,3));
        vecs.push_back(mk(5'b00000,0,1,0, 5'b00000,0,-1,4));
        vecs.push_back(mk(5'b00000,0,1,0, 5'b00000,0,-1,3));
        vecs.push_back(mk(5'b00000,0,1,0, 5'b00000,0,-1,2));
        vecs.push_back(mk(5'b00000,0,1,0, 5'b00000,0,-1,1));
        vecs.push_back(mk(5'b00000,0,0,0, 5'b00000,0,-1,0));
        vecs.push_back(mk(5'b01000,1,0,0, 5'b01000,1, 3,0));
        vecs.push_back(mk(5'b00010,1,0,0, 5'b00010,1, 1,1));
        vecs.push_back(mk(5'b00000,0,1,1, 5'b00000,0,-1,2));
        vecs.push_back(mk(5'b00000,0,1,0, 5'b00000,0,-1,1));
        vecs.push_back(mk(5'b00000,0,0,0, 5'b00000,0,-1,0));

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_s_req", 64'(bus.s_req_o), 64'd0);
        chk("rst_gnt", 64'(bus.m_gnt_o), 64'd0);
        chk("rst_rvalid", 64'(bus.m_r_valid_o), 64'd0);
        chk("rst_outstanding", 64'(bus.outstanding_o), 64'd0);
        chk("rst_proto_err", 64'(bus.proto_err_o), 64'd0);

        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            rd = 32'hCAFE_0000 + 32'(i);
            if (i == 0) begin
                bus.m_req_i = vecs[i].req; bus.s_gnt_i = vecs[i].gnt; bus.s_r_valid_i = vecs[i].rv;
                bus.s_r_opc_i = vecs[i].opc; bus.s_r_rdata_i = rd;
            end else begin
                drive(vecs[i].req, vecs[i].gnt, vecs[i].rv, vecs[i].opc, rd);
            end
            @(negedge clk);
            chk($sformatf("v%0d_gnt", i), 64'(bus.m_gnt_o), 64'(vecs[i].exp_gnt));
            chk($sformatf("v%0d_s_req", i), 64'(bus.s_req_o), 64'(vecs[i].exp_sreq));
            chk($sformatf("v%0d_outstanding", i), 64'(bus.outstanding_o), 64'(vecs[i].exp_out));
            chk($sformatf("v%0d_proto_err", i), 64'(bus.proto_err_o), 64'd0);
            if (vecs[i].exp_sreq) begin
                chk($sformatf("v%0d_s_add", i), 64'(bus.s_add_o), 64'(addr_of(vecs[i].exp_sel)));
                chk($sformatf("v%0d_s_wdata", i), 64'(bus.s_wdata_o), 64'(wdata_of(vecs[i].exp_sel)));
                chk($sformatf("v%0d_s_be", i), 64'(bus.s_be_o), 64'(be_of(vecs[i].exp_sel)));
                chk($sformatf("v%0d_s_wen", i), 64'(bus.s_wen_o), 64'(vecs[i].exp_sel % 2));
            end
            check_rsp(vecs[i].rv, vecs[i].opc, rd);
            if (vecs[i].exp_gnt != '0) sb_q.push_back(vecs[i].exp_sel);
        end
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        // two grants to port 0 left outstanding, then reset discards them
        for (int k = 0; k < 2; k++) begin
            drive(5'b00001, 1'b1, 1'b0, 1'b0, '0);
            @(negedge clk);
            chk("pre_rst_gnt", 64'(bus.m_gnt_o), 64'h01);
            sb_q.push_back(0);
        end
        drive('0, 1'b0, 1'b0, 1'b0, '0);
        rst_ni = 1'b0;
        @(negedge clk);
        chk("pre_rst_outstanding", 64'(bus.outstanding_o), 64'd2);
        sb_q.delete();
        drive('0, 1'b0, 1'b0, 1'b0, '0);
        @(negedge clk);
        chk("mid_rst_outstanding", 64'(bus.outstanding_o), 64'd0);
        drive('0, 1'b0, 1'b1, 1'b0, 32'h5151_0000);
        rst_ni = 1'b1;
        @(negedge clk);
        check_rsp(1'b1, 1'b0, 32'h5151_0000);
        chk("late_rsp_proto_err_before", 64'(bus.proto_err_o), 64'd0);
        for (int k = 0; k < 3; k++) begin
            drive('0, 1'b0, 1'b0, 1'b0, '0);
            @(negedge clk);
            chk("late_rsp_proto_err", 64'(bus.proto_err_o), 64'd1);
            chk("late_rsp_outstanding", 64'(bus.outstanding_o), 64'd0);
        end
        drive('0, 1'b0, 1'b0, 1'b0, '0);
        rst_ni = 1'b0;
        drive('0, 1'b0, 1'b0, 1'b0, '0);
        rst_ni = 1'b1;
        @(negedge clk);
        chk("proto_err_cleared", 64'(bus.proto_err_o), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
